// File: rtl/vga_layer_compositor_if.sv
// ---------------------------------------------------------------------------
// vga_layer_compositor_if
//   Bundles the renderer-facing inputs and the VGA-facing outputs of
//   vga_layer_compositor.
//   Renderer side (driven by master): layer_on, layer_rgb, bg_rgb, blink_mask.
//   Display side (driven by slave):   pixel_tick, pixel_x, pixel_y, frame_start,
//                                     hsync, vsync, red, green, blue.
//   N_LAYERS must match the compositor instance it is connected to.
// ---------------------------------------------------------------------------
interface vga_layer_compositor_if #(
   parameter int unsigned N_LAYERS = 2
);
   logic [N_LAYERS-1:0]   layer_on;
   logic [8*N_LAYERS-1:0] layer_rgb;
   logic [7:0]            bg_rgb;
   logic [N_LAYERS-1:0]   blink_mask;

   logic                  pixel_tick;
   logic [9:0]            pixel_x;
   logic [9:0]            pixel_y;
   logic                  frame_start;
   logic                  hsync;
   logic                  vsync;
   logic [2:0]            red;
   logic [2:0]            green;
   logic [1:0]            blue;

   modport master (
      output layer_on, layer_rgb, bg_rgb, blink_mask,
      input  pixel_tick, pixel_x, pixel_y, frame_start, hsync, vsync, red, green, blue
   );

   modport slave (
      input  layer_on, layer_rgb, bg_rgb, blink_mask,
      output pixel_tick, pixel_x, pixel_y, frame_start, hsync, vsync, red, green, blue
   );
endinterface

// File: rtl/vga_layer_compositor.sv
// ---------------------------------------------------------------------------
// vga_layer_compositor
//   VGA sync generator plus an N-layer priority compositor with a registered
//   RGB332 output. Syncs and video_on are delayed to line up with the
//   renderer latency so that pins change together.
//
// Ports
//   clk    : system clock
//   reset  : asynchronous, active-low reset
//   bus    : vga_layer_compositor_if.slave
//            in : layer_on[N], layer_rgb[8N] (layer i at [8i+7:8i]), bg_rgb,
//                 blink_mask[N]
//            out: pixel_tick, pixel_x, pixel_y, frame_start, hsync, vsync
//                 (active low), red[3], green[3], blue[2]
//
// Configuration
//   VGA_BLINK_EN : when defined, layers selected by blink_mask are hidden
//                  during alternate groups of BLINK_FRAMES frames.
// ---------------------------------------------------------------------------
module vga_layer_compositor #(
   parameter int unsigned H_DISP       = 640,
   parameter int unsigned H_FP         = 16,
   parameter int unsigned H_SYNC       = 96,
   parameter int unsigned H_BP         = 48,
   parameter int unsigned V_DISP       = 480,
   parameter int unsigned V_FP         = 10,
   parameter int unsigned V_SYNC       = 2,
   parameter int unsigned V_BP         = 33,
   parameter int unsigned TICK_DIV     = 2,
   parameter int unsigned N_LAYERS     = 2,
   parameter int unsigned LAYER_LAT    = 1,
   parameter int unsigned BLINK_FRAMES = 30
) (
   input  logic                 clk,
   input  logic                 reset,
   vga_layer_compositor_if.slave bus
);

   localparam int unsigned H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;
   localparam int unsigned DIV_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   // {hsync, vsync, video_on}; value held by alignment stages out of reset
   localparam logic [2:0] SYNC_IDLE = 3'b110;

   // -------------------------------------------------------------------------
   // Pixel strobe
   // -------------------------------------------------------------------------
   logic [DIV_W-1:0] div_q, div_d;
   logic             run_q;
   logic             tick;

   always_comb begin
      if (div_q == DIV_W'(TICK_DIV - 1)) begin
         div_d = '0;
      end else begin
         div_d = div_q + 1'b1;
      end
   end

   // run_q keeps the strobe low while in reset, which matters for TICK_DIV=1
   assign tick = run_q && (div_q == DIV_W'(TICK_DIV - 1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         div_q <= '0;
         run_q <= 1'b0;
      end else begin
         div_q <= div_d;
         run_q <= 1'b1;
      end
   end

   // -------------------------------------------------------------------------
   // Raster counters
   // -------------------------------------------------------------------------
   logic [9:0] x_q, x_d;
   logic [9:0] y_q, y_d;

   always_comb begin
      x_d = x_q;
      y_d = y_q;
      if (tick) begin
         if (x_q == 10'(H_TOTAL - 1)) begin
            x_d = '0;
            if (y_q == 10'(V_TOTAL - 1)) begin
               y_d = '0;
            end else begin
               y_d = y_q + 10'd1;
            end
         end else begin
            x_d = x_q + 10'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         x_q <= '0;
         y_q <= '0;
      end else begin
         x_q <= x_d;
         y_q <= y_d;
      end
   end

   logic frame_start;
   assign frame_start = tick && (x_q == '0) && (y_q == '0);

   // -------------------------------------------------------------------------
   // Raw timing decode and renderer-latency alignment
   // -------------------------------------------------------------------------
   logic       hs_raw, vs_raw, vid_raw;
   logic [2:0] raw;
   logic [2:0] dly;

   always_comb begin
      hs_raw  = !((x_q >= 10'(H_DISP + H_FP)) && (x_q < 10'(H_DISP + H_FP + H_SYNC)));
      vs_raw  = !((y_q >= 10'(V_DISP + V_FP)) && (y_q < 10'(V_DISP + V_FP + V_SYNC)));
      vid_raw = (x_q < 10'(H_DISP)) && (y_q < 10'(V_DISP));
      raw     = {hs_raw, vs_raw, vid_raw};
   end

   generate
      if (LAYER_LAT == 0) begin : g_no_lat
         assign dly = raw;
      end else begin : g_lat
         logic [2:0] pipe_q [LAYER_LAT];

         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               for (int i = 0; i < int'(LAYER_LAT); i++) begin
                  pipe_q[i] <= SYNC_IDLE;
               end
            end else if (tick) begin
               pipe_q[0] <= raw;
               for (int i = 1; i < int'(LAYER_LAT); i++) begin
                  pipe_q[i] <= pipe_q[i-1];
               end
            end
         end

         assign dly = pipe_q[LAYER_LAT-1];
      end
   endgenerate

   // -------------------------------------------------------------------------
   // Effective layer enables (optional blink)
   // -------------------------------------------------------------------------
   logic [N_LAYERS-1:0] layer_eff;

`ifdef VGA_BLINK_EN
   localparam int unsigned FR_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   logic [FR_W-1:0] frame_cnt_q;
   logic            blink_phase_q;
   logic            first_frame_q;

   // The counter counts completed frames: the frame_start that opens the very
   // first frame after reset does not advance it, so frames 0..BLINK_FRAMES-1
   // are all shown with blink_phase=0.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         frame_cnt_q   <= '0;
         blink_phase_q <= 1'b0;
         first_frame_q <= 1'b1;
      end else if (frame_start) begin
         if (first_frame_q) begin
            first_frame_q <= 1'b0;
         end else if (frame_cnt_q == FR_W'(BLINK_FRAMES - 1)) begin
            frame_cnt_q   <= '0;
            blink_phase_q <= ~blink_phase_q;
         end else begin
            frame_cnt_q <= frame_cnt_q + 1'b1;
         end
      end
   end

   assign layer_eff = bus.layer_on & ~({N_LAYERS{blink_phase_q}} & bus.blink_mask);
`else
   logic unused_blink;
   assign unused_blink = ^{bus.blink_mask, 32'(BLINK_FRAMES)};
   assign layer_eff    = bus.layer_on;
`endif

   // -------------------------------------------------------------------------
   // Priority compositor and output registers
   // -------------------------------------------------------------------------
   logic [7:0] rgb_sel;
   logic [7:0] rgb_d, rgb_q;
   logic       hsync_q, vsync_q;

   // Later (higher-index) layers overwrite earlier ones: highest index wins.
   always_comb begin
      rgb_sel = bus.bg_rgb;
      for (int i = 0; i < int'(N_LAYERS); i++) begin
         if (layer_eff[i]) begin
            rgb_sel = bus.layer_rgb[8*i +: 8];
         end
      end
      rgb_d = dly[0] ? rgb_sel : 8'h00;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hsync_q <= 1'b1;
         vsync_q <= 1'b1;
         rgb_q   <= 8'h00;
      end else if (tick) begin
         hsync_q <= dly[2];
         vsync_q <= dly[1];
         rgb_q   <= rgb_d;
      end
   end

   assign bus.pixel_tick  = tick;
   assign bus.pixel_x     = x_q;
   assign bus.pixel_y     = y_q;
   assign bus.frame_start = frame_start;
   assign bus.hsync       = hsync_q;
   assign bus.vsync       = vsync_q;
   assign bus.red         = rgb_q[7:5];
   assign bus.green       = rgb_q[4:2];
   assign bus.blue        = rgb_q[1:0];

endmodule

// File: tb/tb_vga_layer_compositor.sv
// ---------------------------------------------------------------------------
// tb_vga_layer_compositor
//   Self-checking bench for vga_layer_compositor using a shrunken raster so
//   that several full frames fit in a short run. The reference model works
//   from the tick count since reset: pixel position is plain division/modulo,
//   and the pins show the pixel LAYER_LAT+1 ticks old.
// ---------------------------------------------------------------------------
module tb_vga_layer_compositor;

   localparam int unsigned TD    = 2;
   localparam int unsigned HD    = 16;
   localparam int unsigned HFP   = 2;
   localparam int unsigned HS    = 3;
   localparam int unsigned HBP   = 3;
   localparam int unsigned VD    = 8;
   localparam int unsigned VFP   = 1;
   localparam int unsigned VS    = 2;
   localparam int unsigned VBP   = 2;
   localparam int unsigned NL    = 2;
   localparam int unsigned L     = 2;
   localparam int unsigned BF    = 2;
   localparam int unsigned HT    = HD + HFP + HS + HBP;
   localparam int unsigned VT    = VD + VFP + VS + VBP;
   localparam int unsigned FRAME = HT * VT;

`ifdef VGA_BLINK_EN
   localparam bit BLINK = 1'b1;
`else
   localparam bit BLINK = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   vga_layer_compositor_if #(.N_LAYERS(NL)) bus ();

   vga_layer_compositor #(
      .H_DISP       (HD),
      .H_FP         (HFP),
      .H_SYNC       (HS),
      .H_BP         (HBP),
      .V_DISP       (VD),
      .V_FP         (VFP),
      .V_SYNC       (VS),
      .V_BP         (VBP),
      .TICK_DIV     (TD),
      .N_LAYERS     (NL),
      .LAYER_LAT    (L),
      .BLINK_FRAMES (BF)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int          n_checks = 0;
   int          n_fail   = 0;
   int unsigned clk_n;       // rising edges since reset release
   int unsigned n_tick;      // pixel ticks since reset release
   logic [2:0]  hist_q [$];  // {hsync, vsync, video_on} of recent ticks
   logic        exp_hs, exp_vs, exp_vid;
   logic [7:0]  exp_rgb;
   bit          last_tick;

   logic [1:0]  pat_on  [4] = '{2'b11, 2'b01, 2'b00, 2'b10};
   logic [7:0]  pat_exp [4] = '{8'hE0, 8'h1C, 8'h03, 8'hE0};

   function automatic logic [7:0] rgb_pins();
      return {bus.red, bus.green, bus.blue};
   endfunction

   function automatic bit pix_vis(input int unsigned p);
      return ((p % HT) < HD) && (((p / HT) % VT) < VD);
   endfunction

   function automatic bit model_tick_now();
      return (clk_n >= 1) && ((clk_n % TD) == TD - 1);
   endfunction

   function automatic logic [7:0] ref_pixel(input logic [NL-1:0] on,
                                             input logic [8*NL-1:0] rgb,
                                             input logic [7:0] bg,
                                             input logic [NL-1:0] mask,
                                             input int unsigned tick_idx);
      logic [NL-1:0] eff;
      eff = on;
      if (BLINK && (((tick_idx / FRAME) / BF) % 2 == 1)) eff = on & ~mask;
      for (int i = int'(NL) - 1; i >= 0; i--) begin
         if (eff[i]) return rgb[8*i +: 8];
      end
      return bg;
   endfunction

   task automatic model_reset();
      clk_n   = 0;
      n_tick  = 0;
      hist_q.delete();
      for (int i = 0; i < int'(L); i++) hist_q.push_back(3'b110);
      exp_hs  = 1'b1;
      exp_vs  = 1'b1;
      exp_vid = 1'b0;
      exp_rgb = 8'h00;
      last_tick = 1'b0;
   endtask

   task automatic rand_inputs();
      bus.layer_on   = NL'($urandom);
      bus.layer_rgb  = (8*NL)'($urandom);
      bus.bg_rgb     = 8'($urandom);
      bus.blink_mask = NL'($urandom);
   endtask

   // Advances one clock from a falling edge to the next, updating the model
   // with the inputs currently driven.
   task automatic clk_cycle();
      logic [2:0]  d;
      int unsigned xm, ym;
      last_tick = model_tick_now();
      if (last_tick) begin
         xm = n_tick % HT;
         ym = (n_tick / HT) % VT;
         hist_q.push_back({!(xm >= HD + HFP && xm < HD + HFP + HS),
                           !(ym >= VD + VFP && ym < VD + VFP + VS),
                           (xm < HD && ym < VD)});
         d       = hist_q.pop_front();
         exp_hs  = d[2];
         exp_vs  = d[1];
         exp_vid = d[0];
         exp_rgb = d[0] ? ref_pixel(bus.layer_on, bus.layer_rgb, bus.bg_rgb,
                                    bus.blink_mask, n_tick) : 8'h00;
         n_tick++;
      end
      @(posedge clk);
      clk_n++;
      @(negedge clk);
   endtask

   task automatic release_reset();
      model_reset();
      reset = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      rand_inputs();
      repeat (2) @(negedge clk);
      n_checks += 7;
      if (bus.hsync !== 1'b1) begin n_fail++; $display("FAIL reset_hsync got %b want 1", bus.hsync); end
      if (bus.vsync !== 1'b1) begin n_fail++; $display("FAIL reset_vsync got %b want 1", bus.vsync); end
      if (rgb_pins() !== 8'h00) begin n_fail++; $display("FAIL reset_rgb got %h want 00", rgb_pins()); end
      if (bus.pixel_x !== 10'd0) begin n_fail++; $display("FAIL reset_x got %0d want 0", bus.pixel_x); end
      if (bus.pixel_y !== 10'd0) begin n_fail++; $display("FAIL reset_y got %0d want 0", bus.pixel_y); end
      if (bus.pixel_tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick got %b want 0", bus.pixel_tick); end
      if (bus.frame_start !== 1'b0) begin n_fail++; $display("FAIL reset_fs got %b want 0", bus.frame_start); end
      release_reset();
   endtask

   task automatic test_sync_timing();
      int          last_fs = -1;
      int unsigned ex, ey;
      bit          efs;
      for (int c = 0; c < int'(2 * FRAME * TD + 20); c++) begin
         rand_inputs();
         clk_cycle();
         ex  = n_tick % HT;
         ey  = (n_tick / HT) % VT;
         efs = model_tick_now() && ex == 0 && ey == 0;
         n_checks += 6;
         if (bus.pixel_tick !== model_tick_now()) begin
            n_fail++; $display("FAIL tick clk %0d got %b want %b", clk_n, bus.pixel_tick, model_tick_now());
         end
         if (bus.pixel_x !== 10'(ex)) begin n_fail++; $display("FAIL pixel_x got %0d want %0d", bus.pixel_x, ex); end
         if (bus.pixel_y !== 10'(ey)) begin n_fail++; $display("FAIL pixel_y got %0d want %0d", bus.pixel_y, ey); end
         if (bus.frame_start !== efs) begin n_fail++; $display("FAIL frame_start got %b want %b", bus.frame_start, efs); end
         if (bus.hsync !== exp_hs) begin n_fail++; $display("FAIL hsync tick %0d got %b want %b", n_tick, bus.hsync, exp_hs); end
         if (bus.vsync !== exp_vs) begin n_fail++; $display("FAIL vsync tick %0d got %b want %b", n_tick, bus.vsync, exp_vs); end
         if (bus.frame_start === 1'b1) begin
            if (last_fs >= 0) begin
               n_checks++;
               if (int'(clk_n) - last_fs != int'(FRAME * TD)) begin
                  n_fail++; $display("FAIL frame_period got %0d want %0d", int'(clk_n) - last_fs, FRAME * TD);
               end
            end
            last_fs = int'(clk_n);
         end
      end
   endtask

   task automatic test_composite_random();
      for (int c = 0; c < int'(2 * FRAME * TD); c++) begin
         rand_inputs();
         clk_cycle();
         n_checks++;
         if (rgb_pins() !== exp_rgb) begin
            n_fail++; $display("FAIL composite tick %0d got %h want %h", n_tick, rgb_pins(), exp_rgb);
         end
      end
   endtask

   task automatic test_priority();
      bit done;
      bus.layer_rgb  = 16'hE01C;
      bus.bg_rgb     = 8'h03;
      bus.blink_mask = '0;
      for (int k = 0; k < 4; k++) begin
         bus.layer_on = pat_on[k];
         done = 1'b0;
         for (int c = 0; c < int'(FRAME * TD) && !done; c++) begin
            clk_cycle();
            if (last_tick && n_tick > L && pix_vis(n_tick - 1 - L)) begin
               done = 1'b1;
               n_checks++;
               if (rgb_pins() !== pat_exp[k]) begin
                  n_fail++; $display("FAIL priority on=%b got %h want %h", pat_on[k], rgb_pins(), pat_exp[k]);
               end
            end
         end
         if (!done) begin
            n_checks++; n_fail++; $display("FAIL priority_timeout on=%b got none want visible pixel", pat_on[k]);
         end
      end
   endtask

   task automatic test_blanking();
      logic [7:0] e;
      bus.layer_on = '0;
      bus.bg_rgb   = 8'hFF;
      for (int c = 0; c < int'(FRAME * TD); c++) begin
         clk_cycle();
         if (last_tick && n_tick > L) begin
            e = pix_vis(n_tick - 1 - L) ? 8'hFF : 8'h00;
            n_checks++;
            if (rgb_pins() !== e) begin
               n_fail++; $display("FAIL blanking tick %0d got %h want %h", n_tick, rgb_pins(), e);
            end
         end
      end
   endtask

   task automatic test_alignment();
      int unsigned since0 = 1000;
      int unsigned y0     = 0;
      bit          enz, ehs;
      bus.layer_on = '0;
      for (int c = 0; c < int'(FRAME * TD); c++) begin
         if (model_tick_now()) begin
            bus.bg_rgb = (n_tick >= L && ((n_tick - L) % HT) == 0) ? 8'hFF : 8'h00;
            if (bus.pixel_x == 10'd0) begin
               since0 = 0;
               y0     = bus.pixel_y;
            end
         end
         clk_cycle();
         if (last_tick) begin
            since0++;
            enz = (since0 == L + 1) && (y0 < VD);
            n_checks++;
            if ((rgb_pins() != 8'h00) !== enz) begin
               n_fail++; $display("FAIL align_rgb since_x0 %0d got %h want nonzero=%b", since0, rgb_pins(), enz);
            end
            if (since0 <= HT) begin
               ehs = !(since0 >= HD + HFP + L + 1 && since0 < HD + HFP + HS + L + 1);
               n_checks++;
               if (bus.hsync !== ehs) begin
                  n_fail++; $display("FAIL align_hsync since_x0 %0d got %b want %b", since0, bus.hsync, ehs);
               end
            end
         end
      end
   endtask

   task automatic test_blink();
      logic [7:0]  e;
      int unsigned p;
      reset = 1'b0;
      @(negedge clk);
      bus.layer_on   = 2'b11;
      bus.layer_rgb  = 16'hE01C;
      bus.bg_rgb     = 8'h03;
      bus.blink_mask = 2'b10;
      release_reset();
      for (int c = 0; c < int'(4 * FRAME * TD + 40); c++) begin
         clk_cycle();
         if (last_tick && n_tick > L) begin
            p = n_tick - 1 - L;
            if (pix_vis(p)) begin
               e = (BLINK && (((p / FRAME) / BF) % 2 == 1)) ? 8'h1C : 8'hE0;
               n_checks++;
               if (rgb_pins() !== e) begin
                  n_fail++; $display("FAIL blink frame %0d got %h want %h", p / FRAME, rgb_pins(), e);
               end
            end
         end
      end
   endtask

   task automatic test_reset_midframe();
      bit found = 1'b0;
      bus.layer_on = '0;
      bus.bg_rgb   = 8'hFF;
      for (int c = 0; c < int'(FRAME * TD + 10) && !found; c++) begin
         clk_cycle();
         if (bus.pixel_x == 10'd10 && bus.pixel_y == 10'd5) found = 1'b1;
      end
      n_checks += 2;
      if (!found) begin n_fail++; $display("FAIL midframe_reach got none want x=10,y=5"); end
      if (rgb_pins() !== 8'hFF) begin n_fail++; $display("FAIL midframe_pre_rgb got %h want ff", rgb_pins()); end
      reset = 1'b0;
      #1;
      n_checks += 5;
      if (bus.hsync !== 1'b1) begin n_fail++; $display("FAIL midframe_hsync got %b want 1", bus.hsync); end
      if (bus.vsync !== 1'b1) begin n_fail++; $display("FAIL midframe_vsync got %b want 1", bus.vsync); end
      if (rgb_pins() !== 8'h00) begin n_fail++; $display("FAIL midframe_rgb got %h want 00", rgb_pins()); end
      if (bus.pixel_x !== 10'd0) begin n_fail++; $display("FAIL midframe_x got %0d want 0", bus.pixel_x); end
      if (bus.pixel_y !== 10'd0) begin n_fail++; $display("FAIL midframe_y got %0d want 0", bus.pixel_y); end
      repeat (3) @(negedge clk);
      release_reset();
      found = 1'b0;
      for (int c = 0; c < int'(2 * TD + 2) && !found; c++) begin
         clk_cycle();
         if (last_tick) found = 1'b1;
      end
      n_checks += 3;
      if (!found) begin n_fail++; $display("FAIL restart_tick got none want tick"); end
      if (bus.pixel_x !== 10'd1) begin n_fail++; $display("FAIL restart_x got %0d want 1", bus.pixel_x); end
      if (bus.pixel_y !== 10'd0) begin n_fail++; $display("FAIL restart_y got %0d want 0", bus.pixel_y); end
   endtask

   initial begin
      test_reset();
      test_sync_timing();
      test_composite_random();
      test_priority();
      test_blanking();
      test_alignment();
      test_blink();
      test_reset_midframe();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
